// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream valid/ready handshake into the instruction memory loader.
// The master drives bytes and the slave (loader) signals when it can take one.
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream (length byte, then N little-endian
// 32-bit words) and holds the core in reset until the image is loaded.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  in_if,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_rst_n,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW:0]   word_count
);

  localparam int unsigned WCW = AW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StCsum,
`endif
    StDone,
    StErr
  } state_e;

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            imem_we_q, imem_we_d;
  logic [AW-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]     imem_wdata_q, imem_wdata_d;
  logic            core_rst_n_q, core_rst_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [WCW-1:0]  word_count_q, word_count_d;
  logic [WCW-1:0]  len_q, len_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  // Bytes b0..b2 of the word in flight, b0 ends up in the low byte.
  logic [23:0]     word_buf_q, word_buf_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic            accept;
  logic            len_ok;
  logic [WCW-1:0]  word_next;

  assign accept    = in_if.in_valid & in_ready_q;
  assign len_ok    = (in_if.in_data != 8'd0) && (32'(in_if.in_data) <= DEPTH);
  assign word_next = word_count_q + WCW'(1);

  // Next-state and next-output computation; every output is derived from the next state.
  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    word_count_d = word_count_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    word_buf_d   = word_buf_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d      = StLen;
          word_count_d = '0;
        end
      end
      StLen: begin
        if (accept) begin
          if (len_ok) begin
            len_d        = WCW'(in_if.in_data);
            word_count_d = '0;
            byte_idx_d   = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d       = in_if.in_data;
`endif
            state_d      = StData;
          end else begin
            state_d = StErr;
          end
        end
      end
      StData: begin
        if (accept) begin
          word_buf_d = {in_if.in_data, word_buf_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q + in_if.in_data;
`endif
          if (byte_idx_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_count_q[AW-1:0];
            imem_wdata_d = {in_if.in_data, word_buf_q};
            word_count_d = word_next;
            byte_idx_d   = 2'd0;
            if (word_next == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = StCsum;
`else
              state_d = StDone;
`endif
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) begin
          state_d = (in_if.in_data == csum_q) ? StDone : StErr;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StLen) || (state_d == StData);
`ifdef IMEM_LOADER_CHECKSUM_EN
    busy_d = busy_d || (state_d == StCsum);
`endif
    in_ready_d   = busy_d;
    done_d       = (state_d == StDone);
    core_rst_n_d = (state_d == StDone);
    error_d      = (state_d == StErr);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
      len_q        <= '0;
      byte_idx_q   <= '0;
      word_buf_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      word_count_q <= word_count_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      word_buf_q   <= word_buf_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign imem_we        = imem_we_q;
  assign imem_addr      = imem_addr_q;
  assign imem_wdata     = imem_wdata_q;
  assign core_rst_n     = core_rst_n_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign word_count     = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized loads checked every cycle against a byte-position
// model of the loader, plus literal expectations for the documented example streams.
module tb_imem_loader;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n, busy, done, error;
  logic [AW:0]   word_count;

  imem_loader_if sif ();

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_if      (sif),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks the position of each accepted byte within the current load.
  bit          m_started = 1'b0;
  bit          m_loading, m_done, m_err, m_we;
  int          m_n, m_got, m_wc, m_addr;
  logic [31:0] m_wdata, m_word;
  logic [7:0]  m_sum;

  always @(posedge clk) begin
    logic [7:0] b;
    int p;
    if (!rst) begin
      m_started = 1'b1;
      m_loading = 1'b0; m_done = 1'b0; m_err = 1'b0; m_we = 1'b0;
      m_wc = 0; m_addr = 0; m_wdata = '0; m_got = 0;
    end else begin
      m_we = 1'b0;
      if (m_loading) begin
        if (sif.in_valid === 1'b1) begin
          b = sif.in_data;
          if (m_got == 0) begin
            if (b >= 8'd1 && 32'(b) <= DEPTH) begin
              m_n = int'(b); m_sum = b; m_got = 1;
            end else begin
              m_loading = 1'b0; m_err = 1'b1;
            end
          end else if (m_got <= 4 * m_n) begin
            p = m_got - 1;
            m_word[8*(p%4) +: 8] = b;
            m_sum = m_sum + b;
            if (p % 4 == 3) begin
              m_we = 1'b1; m_addr = p / 4; m_wdata = m_word; m_wc = p / 4 + 1;
            end
            m_got++;
`ifndef IMEM_LOADER_CHECKSUM_EN
            if (m_got == 4 * m_n + 1) begin
              m_loading = 1'b0; m_done = 1'b1;
            end
`endif
          end else begin
            m_loading = 1'b0;
            if (b == m_sum) m_done = 1'b1;
            else m_err = 1'b1;
          end
        end
      end else if (start === 1'b1) begin
        m_loading = 1'b1; m_got = 0; m_done = 1'b0; m_err = 1'b0; m_wc = 0;
      end
    end
  end

  // Write log and shadow of what the DUT actually wrote into instruction memory.
  logic [AW-1:0] wlog_addr[$];
  logic [31:0]   wlog_data[$];
  logic [31:0]   d_mem[DEPTH];

  always @(negedge clk) begin
    if (m_started) begin
      check("in_ready",   64'(sif.in_ready), 64'(m_loading));
      check("busy",       64'(busy),         64'(m_loading));
      check("done",       64'(done),         64'(m_done));
      check("error",      64'(error),        64'(m_err));
      check("core_rst_n", 64'(core_rst_n),   64'(m_done));
      check("imem_we",    64'(imem_we),      64'(m_we));
      check("word_count", 64'(word_count),   64'(m_wc));
      if (m_we) begin
        check("imem_addr",  64'(imem_addr),  64'(m_addr));
        check("imem_wdata", 64'(imem_wdata), 64'(m_wdata));
      end
      if (imem_we === 1'b1) begin
        wlog_addr.push_back(imem_addr);
        wlog_data.push_back(imem_wdata);
        d_mem[imem_addr] = imem_wdata;
      end
    end
  end

  task automatic idle_bus();
    sif.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    sif.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte after `gap` idle cycles; noise toggles start randomly while busy.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      sif.in_valid = 1'b0;
      start = noise && ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    sif.in_valid = 1'b1;
    sif.in_data  = b;
    ok = 1'b0;
    for (int w = 0; w < 40 && !ok; w++) begin
      start = noise && ($urandom_range(0, 3) == 0);
      if (sif.in_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    check("byte_accepted", 64'(ok), 64'd1);
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input int gap, input bit noise);
    foreach (q[i]) send_byte(q[i], gap, noise);
    idle_bus();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   64'(sif.in_ready), 64'd0);
    check({tag, "_imem_we"},    64'(imem_we),      64'd0);
    check({tag, "_imem_addr"},  64'(imem_addr),    64'd0);
    check({tag, "_imem_wdata"}, 64'(imem_wdata),   64'd0);
    check({tag, "_core_rst_n"}, 64'(core_rst_n),   64'd0);
    check({tag, "_busy"},       64'(busy),         64'd0);
    check({tag, "_done"},       64'(done),         64'd0);
    check({tag, "_error"},      64'(error),        64'd0);
    check({tag, "_word_count"}, 64'(word_count),   64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  n2[$];
    logic [7:0]  q[$];
    logic [31:0] words[$];
    logic [31:0] word;
    logic [7:0]  s;
    int          base, n, kind, gap, cut;

    for (int i = 0; i < int'(DEPTH); i++) d_mem[i] = '0;

    // Reset with in_valid high: nothing consumed, outputs at reset values.
    rst = 1'b0; sif.in_valid = 1'b1; sif.in_data = 8'h02; start = 1'b0;
    tick(2);
    check_reset_outputs("reset");
    rst = 1'b1; sif.in_valid = 1'b0;
    tick(1);
    check("reset_idle_ready", 64'(sif.in_ready), 64'd0);

    // Back-to-back N=2 load.
    n2 = '{8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h33, 8'h02, 8'h21, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    n2.push_back(8'hBB);
`endif
    base = wlog_addr.size();
    do_start();
    check("start_ready_next", 64'(sif.in_ready), 64'd1);
    send_bytes(n2, 0, 1'b0);
    tick(2);
    check("n2_done",       64'(done),         64'd1);
    check("n2_core_rst_n", 64'(core_rst_n),   64'd1);
    check("n2_word_count", 64'(word_count),   64'd2);
    check("n2_busy",       64'(busy),         64'd0);
    check("n2_writes",     64'(wlog_addr.size() - base), 64'd2);
    if (wlog_addr.size() >= base + 2) begin
      check("n2_addr0", 64'(wlog_addr[base]),     64'd0);
      check("n2_data0", 64'(wlog_data[base]),     64'h0050_0013);
      check("n2_addr1", 64'(wlog_addr[base + 1]), 64'd1);
      check("n2_data1", 64'(wlog_data[base + 1]), 64'h0021_0233);
    end

    // Same stream with in_valid toggling every cycle.
    base = wlog_addr.size();
    do_start();
    check("restart_done_clears", 64'(done), 64'd0);
    send_bytes(n2, 1, 1'b0);
    tick(2);
    check("gap_done",   64'(done), 64'd1);
    check("gap_writes", 64'(wlog_addr.size() - base), 64'd2);
    if (wlog_addr.size() >= base + 2) begin
      check("gap_addr0", 64'(wlog_addr[base]),     64'd0);
      check("gap_data0", 64'(wlog_data[base]),     64'h0050_0013);
      check("gap_addr1", 64'(wlog_addr[base + 1]), 64'd1);
      check("gap_data1", 64'(wlog_data[base + 1]), 64'h0021_0233);
    end

    // Bad length bytes 00 and 33.
    base = wlog_addr.size();
    do_start();
    send_byte(8'h00, 0, 1'b0); idle_bus();
    tick(1);
    check("len0_error",      64'(error),      64'd1);
    check("len0_core_rst_n", 64'(core_rst_n), 64'd0);
    do_start();
    check("len0_error_clear", 64'(error),        64'd0);
    check("len0_relen_ready", 64'(sif.in_ready), 64'd1);
    send_byte(8'h21, 0, 1'b0); idle_bus();
    tick(1);
    check("len33_error",      64'(error),      64'd1);
    check("len33_core_rst_n", 64'(core_rst_n), 64'd0);
    check("badlen_no_write",  64'(wlog_addr.size() - base), 64'd0);

    // Reset after 6 accepted bytes of an N=2 load.
    base = wlog_addr.size();
    do_start();
    for (int i = 0; i < 6; i++) send_byte(n2[i], 0, 1'b0);
    rst = 1'b0; idle_bus();
    tick(1);
    rst = 1'b1;
    check_reset_outputs("midrst");
    tick(3);
    check("midrst_writes", 64'(wlog_addr.size() - base), 64'd1);
    if (wlog_addr.size() >= base + 1) begin
      check("midrst_addr0", 64'(wlog_addr[base]), 64'd0);
      check("midrst_data0", 64'(wlog_data[base]), 64'h0050_0013);
    end
    do_start();
    send_bytes(n2, 0, 1'b0);
    tick(2);
    check("midrst_reload_done", 64'(done), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good (0x64) and bad (0x65).
    q = '{8'h01, 8'h13, 8'h00, 8'h50, 8'h00, 8'h64};
    do_start();
    send_bytes(q, 0, 1'b0);
    tick(1);
    check("csum_good_done", 64'(done), 64'd1);
    base = wlog_addr.size();
    q[5] = 8'h65;
    do_start();
    send_bytes(q, 0, 1'b0);
    tick(1);
    check("csum_bad_error",      64'(error),      64'd1);
    check("csum_bad_core_rst_n", 64'(core_rst_n), 64'd0);
    check("csum_bad_writes",     64'(wlog_addr.size() - base), 64'd1);
    if (wlog_addr.size() >= base + 1) begin
      check("csum_bad_addr0", 64'(wlog_addr[base]), 64'd0);
      check("csum_bad_data0", 64'(wlog_data[base]), 64'h0050_0013);
    end
`endif

    // Randomized loads: bad lengths, corrupted checksums, mid-load resets, gaps, start noise.
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(0, 2);
      q = {};
      words = {};
      if (kind == 0) begin
        q.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(DEPTH + 1, 255)));
        do_start();
        send_bytes(q, gap, 1'b1);
        tick(2);
        check("rand_badlen_error", 64'(error), 64'd1);
      end else begin
        n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, DEPTH)) : int'($urandom_range(1, 6));
        q.push_back(8'(n));
        s = 8'(n);
        for (int i = 0; i < n; i++) begin
          word = $urandom;
          words.push_back(word);
          for (int k = 0; k < 4; k++) begin
            q.push_back(word[8*k +: 8]);
            s = s + word[8*k +: 8];
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        q.push_back((kind == 1) ? s + 8'd1 : s);
`endif
        cut = (kind == 2) ? int'($urandom_range(1, q.size() - 1)) : q.size();
        do_start();
        for (int i = 0; i < cut; i++) send_byte(q[i], gap, 1'b1);
        idle_bus();
        if (kind == 2) begin
          rst = 1'b0;
          tick(1);
          rst = 1'b1;
          check("rand_rst_busy",       64'(busy),       64'd0);
          check("rand_rst_word_count", 64'(word_count), 64'd0);
          tick(1);
        end else begin
          tick(2);
`ifdef IMEM_LOADER_CHECKSUM_EN
          check("rand_done",  64'(done),  (kind == 1) ? 64'd0 : 64'd1);
          check("rand_error", 64'(error), (kind == 1) ? 64'd1 : 64'd0);
`else
          check("rand_done",  64'(done),  64'd1);
          check("rand_error", 64'(error), 64'd0);
`endif
          for (int i = 0; i < n; i++) check("rand_mem_word", 64'(d_mem[i]), 64'(words[i]));
        end
      end
    end

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot loader that fills the fetch stage's instruction memory from an external byte stream before the core runs. It accepts a length byte followed by little-endian 32-bit instruction words over a valid/ready byte interface. Each word goes out on a one-cycle write port into instruction memory. The block holds the core in reset until the image is fully and correctly loaded.

## Interface
- DEPTH, 32, instruction memory size in words (maximum loadable N)
- AW, 5, instruction memory word-address width; must satisfy 2^AW >= DEPTH
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- start  input  1  begin a load; sampled in IDLE, DONE and ERR only
- in_valid  input  1  stream byte valid
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  instruction memory write strobe, one-cycle pulse per word
- imem_addr  output  AW  word address (byte address / 4) of current write
- imem_wdata  output  32  assembled instruction word
- core_rst_n  output  1  active-low reset to the core; low while not DONE
- busy  output  1  load in progress
- done  output  1  image loaded successfully
- error  output  1  load aborted: bad length or checksum mismatch
- word_count  output  AW+1  words written in the current load

## Operation
- Transfer: a byte is consumed on a rising clk edge where in_valid & in_ready. At most one byte is consumed per cycle.
- in_ready is a function of state only. It is 1 in LEN, DATA and CSUM, and 0 otherwise.
- States and transitions:
  - IDLE: start -> LEN.
  - LEN: accept byte N.
    - N in 1..DEPTH: latch N, clear word_count and the byte index, go to DATA.
    - Otherwise: go to ERR.
  - DATA: bytes arrive in order b0..b3; word = {b3,b2,b1,b0}.
    - On acceptance of b3, the next cycle has imem_we=1, imem_addr=word_count, imem_wdata=word, and word_count increments.
    - After the last (Nth) word: go to DONE, or to CSUM when checksum is enabled.
    - DATA keeps in_ready=1 during the write pulse, so the write never stalls the stream.
  - DONE: done=1, core_rst_n=1, busy=0. start -> LEN; done clears and core_rst_n goes low on the next cycle.
  - ERR: error=1, core_rst_n=0. start -> LEN and error clears.
- busy is 1 in LEN, DATA and CSUM.
- start is ignored while busy.
- The loader never clears instruction memory. Words already written stay written after ERR or reset.
- Addresses run 0..N-1 with no wrap; the length check makes overflow impossible.

## Timing
- Reset values of all outputs: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, busy=0, done=0, error=0, word_count=0. State=IDLE.
- Reset asserted at any point returns to IDLE on that edge. A partial word is discarded and no imem_we pulse is issued for it.
- start high in IDLE: in_ready=1 on the next cycle.
- Write latency: imem_we is asserted exactly 1 cycle after the edge accepting b3. imem_addr and imem_wdata are valid in that same cycle. imem_we is 0 in all other cycles.
- Completion without checksum: the state enters DONE on the edge accepting the final b3. done, core_rst_n and the final imem_we pulse all appear in the same cycle.
- Minimum load time is 1+4N accepted bytes, plus 1 with checksum. Gaps in in_valid only stretch this; they never duplicate or drop bytes.
- All outputs are registered.

## Configuration
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word, the state goes to CSUM and accepts one byte.
  - Checksum = 8-bit sum, modulo 256, of the length byte and all 4N payload bytes.
  - Match -> DONE; mismatch -> ERR.
  - Completion (done, core_rst_n=1) is one cycle after the edge accepting the checksum byte.
  - The final word write still happens before the checksum compare. A failed load leaves the image in memory with the core held in reset.
- Undefined: there is no CSUM state and no accumulator logic. The state goes directly DATA -> DONE.

## Test plan
- Reset: rst=0 for 2 cycles with in_valid=1 -> all outputs at their reset values, and no byte is consumed.
- Back-to-back load, N=2: start, then bytes 02, 13 00 50 00, 33 02 21 00 with in_valid held high -> imem_we pulse at addr 0 with 0x00500013, then at addr 1 with 0x00210233. Final state: done=1, core_rst_n=1, word_count=2, busy=0.
- Stream gaps: same stream with in_valid toggling every cycle -> exactly two imem_we pulses with identical addresses and data, and no duplicates.
- Bad length: length byte 00 -> error=1, core_rst_n=0, no imem_we. With DEPTH=32, byte 21 (33) gives the same result. Asserting start afterwards clears error and re-enters LEN.
- Reset mid-load: with N=2, assert rst after 6 bytes are accepted -> IDLE with outputs at reset values. Word 0 was written, and no write occurs for word 1. A fresh full load then reaches DONE.
- Checksum (IMEM_LOADER_CHECKSUM_EN): bytes 01, 13 00 50 00, then checksum byte 64 -> done=1. The same load with checksum byte 65 -> error=1 and core_rst_n=0, with imem_we for addr 0 still observed.
